// File: rtl/row_len_gen.sv
// Row-length generator: turns a CSR row-pointer stream ptr[0..N] into one
// row length (ptr[i+1]-ptr[i]) per row, behind a 2-entry skid buffer.
module row_len_gen #(
    parameter int unsigned PTR_W     = 32,
    parameter bit          SKIP_ZERO = 1'b0,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ptr_valid,
    input  logic [PTR_W-1:0] ptr_data,
    input  logic             ptr_last,
    output logic             ptr_ready,
    output logic             times_valid,
    output logic [PTR_W-1:0] times_data,
    input  logic             times_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] rows_sent
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   prev_ptr_q, prev_ptr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   skid_q, skid_d;
    logic [1:0]         count_q, count_d;
    logic               ptr_ready_q, ptr_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   rows_sent_q, rows_sent_d;

    logic               ptr_acc;
    logic               pop;
    logic               push;
    logic               ptr_dec;
    logic [PTR_W-1:0]   len;

    assign ptr_acc = ptr_valid && ptr_ready_q;
    assign pop     = (count_q != 2'd0) && times_ready;
    assign ptr_dec = ptr_data < prev_ptr_q;
    // A decreasing pointer yields a zero-length row instead of a wrapped value.
    assign len     = ptr_dec ? '0 : (ptr_data - prev_ptr_q);

    // Next-state logic for the FSM, the skid buffer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        prev_ptr_d  = prev_ptr_q;
        head_d      = head_q;
        skid_d      = skid_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rows_sent_d = rows_sent_q;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ptr_acc) begin
                    prev_ptr_d = ptr_data;
                    if (ptr_last) begin
                        // Lone pointer: a matrix with zero rows.
                        done_d = 1'b1;
                    end else begin
                        state_d     = StRun;
                        busy_d      = 1'b1;
                        rows_sent_d = '0;
                    end
                end
            end
            StRun: begin
                if (ptr_acc) begin
                    prev_ptr_d  = ptr_data;
                    rows_sent_d = rows_sent_q + CNT_W'(1);
                    if (ptr_dec) begin
                        err_d = 1'b1;
                    end
                    push = !(SKIP_ZERO && (len == '0));
                    if (ptr_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Head register drives the output; skid holds the second entry.
        if (count_q == 2'd0) begin
            if (push) begin
                head_d  = len;
                count_d = 2'd1;
            end
        end else if (count_q == 2'd1) begin
            if (pop && push) begin
                head_d = len;
            end else if (pop) begin
                count_d = 2'd0;
            end else if (push) begin
                skid_d  = len;
                count_d = 2'd2;
            end
        end else begin
            if (pop) begin
                head_d  = skid_q;
                count_d = 2'd1;
            end
        end

        // The last-flagged entry is always the final one pushed, so an empty
        // buffer while draining means it (or a skipped last row) has been handed off.
        if ((state_d == StDrain) && (count_d == 2'd0)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        ptr_ready_d = (count_d != 2'd2) && (state_d != StDrain);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            prev_ptr_q  <= '0;
            head_q      <= '0;
            skid_q      <= '0;
            count_q     <= 2'd0;
            ptr_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rows_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_ptr_q  <= prev_ptr_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            count_q     <= count_d;
            ptr_ready_q <= ptr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rows_sent_q <= rows_sent_d;
        end
    end

    assign ptr_ready   = ptr_ready_q;
    assign times_valid = (count_q != 2'd0);
    assign times_data  = head_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rows_sent   = rows_sent_q;

endmodule

// File: tb/tb_row_len_gen.sv
// Directed bench for row_len_gen: default instance plus a SKIP_ZERO=1 instance.
module tb_row_len_gen;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        ptr_valid, ptr_last, ptr_ready, times_valid, times_ready;
    logic        busy, done, err;
    logic [31:0] ptr_data, times_data, rows_sent;

    logic        ptr_valid1, ptr_last1, ptr_ready1, times_valid1, times_ready1;
    logic        busy1, done1, err1;
    logic [31:0] ptr_data1, times_data1, rows_sent1;

    row_len_gen #(.PTR_W(32), .SKIP_ZERO(1'b0), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .ptr_valid(ptr_valid), .ptr_data(ptr_data), .ptr_last(ptr_last), .ptr_ready(ptr_ready),
        .times_valid(times_valid), .times_data(times_data), .times_ready(times_ready),
        .busy(busy), .done(done), .err(err), .rows_sent(rows_sent)
    );

    row_len_gen #(.PTR_W(32), .SKIP_ZERO(1'b1), .CNT_W(32)) dut_skip (
        .clk(clk), .rstn(rstn),
        .ptr_valid(ptr_valid1), .ptr_data(ptr_data1), .ptr_last(ptr_last1),
        .ptr_ready(ptr_ready1),
        .times_valid(times_valid1), .times_data(times_data1), .times_ready(times_ready1),
        .busy(busy1), .done(done1), .err(err1), .rows_sent(rows_sent1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation state collected at the falling edge.
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    logic [31:0] rx1_q[$];
    int          rx1_cyc[$];
    int          done_cnt = 0, done_cyc = 0, done1_cnt = 0, done1_cyc = 0;
    bit          busy_seen = 0;
    int          stall_viol = 0, full_viol = 0, occ = 0;
    bit          mdl_run = 0;
    bit          stall_pend = 0;
    logic [31:0] stall_data = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            occ = 0;
            mdl_run = 0;
            stall_pend = 0;
        end else begin
            if (stall_pend && (!times_valid || times_data !== stall_data)) stall_viol++;
            stall_pend = times_valid && !times_ready;
            stall_data = times_data;
            if (occ == 2 && ptr_ready) full_viol++;
            if (times_valid && times_ready) begin
                rx_q.push_back(times_data);
                rx_cyc.push_back(cyc);
                occ--;
            end
            if (ptr_valid && ptr_ready) begin
                if (mdl_run) begin
                    occ++;
                    if (ptr_last) mdl_run = 0;
                end else if (!ptr_last) begin
                    mdl_run = 1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1;
            if (times_valid1 && times_ready1) begin
                rx1_q.push_back(times_data1);
                rx1_cyc.push_back(cyc);
            end
            if (done1) begin
                done1_cnt++;
                done1_cyc = cyc;
            end
        end
    end

    task automatic clear_obs();
        rx_q.delete();
        rx_cyc.delete();
        rx1_q.delete();
        rx1_cyc.delete();
        done_cnt = 0;
        done1_cnt = 0;
        busy_seen = 0;
        stall_viol = 0;
        full_viol = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        ptr_valid = 1'b1;
        ptr_data = d;
        ptr_last = l;
        @(negedge clk);
        while (!ptr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ptr_ready) begin
            failures++;
            $display("FAIL send_timeout: ptr_ready=%0b required 1 for ptr %0d", ptr_ready, d);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        ptr_valid = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d, input logic l);
        int n = 0;
        ptr_valid1 = 1'b1;
        ptr_data1 = d;
        ptr_last1 = l;
        @(negedge clk);
        while (!ptr_ready1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ptr_ready1) begin
            failures++;
            $display("FAIL send1_timeout: ptr_ready=%0b required 1 for ptr %0d", ptr_ready1, d);
        end
        @(posedge clk);
        #1;
        ptr_valid1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy || busy1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || busy1) begin
            failures++;
            $display("FAIL idle_timeout: busy=%0b busy_skip=%0b required 0", busy, busy1);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ptr_valid = 0; ptr_data = 0; ptr_last = 0; times_ready = 1;
        ptr_valid1 = 0; ptr_data1 = 0; ptr_last1 = 0; times_ready1 = 1;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ptr_ready, times_valid, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: rdy,vld,busy,done,err=%b required 00000",
                     {ptr_ready, times_valid, busy, done, err});
        end
        checks++;
        if (times_data !== 32'd0 || rows_sent !== 32'd0) begin
            failures++;
            $display("FAIL reset_values: times_data=%0d rows_sent=%0d required 0 0",
                     times_data, rows_sent);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ptr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: ptr_ready=%0b required 1", ptr_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int c;
        clear_obs();
        send(32'd0, 1'b0);
        send(32'd3, 1'b0);
        c = acc_cyc;
        send(32'd3, 1'b0);
        send(32'd7, 1'b1);
        wait_idle();
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 32'd3 || rx_q[1] !== 32'd0 || rx_q[2] !== 32'd4) begin
            failures++;
            $display("FAIL basic_data: got %p required '{3,0,4}", rx_q);
        end
        checks++;
        if (rx_cyc.size() != 3 || rx_cyc[0] != c + 1 || rx_cyc[1] != c + 2 || rx_cyc[2] != c + 3)
        begin
            failures++;
            $display("FAIL basic_timing: got %p required %0d,%0d,%0d", rx_cyc, c + 1, c + 2, c + 3);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != c + 4) begin
            failures++;
            $display("FAIL basic_done: count=%0d cyc=%0d required 1 at %0d",
                     done_cnt, done_cyc, c + 4);
        end
        checks++;
        if (rows_sent !== 32'd3 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_rows: rows_sent=%0d err=%0b required 3 0", rows_sent, err);
        end
    endtask

    task automatic test_skip_zero();
        clear_obs();
        send1(32'd0, 1'b0);
        send1(32'd3, 1'b0);
        send1(32'd3, 1'b0);
        send1(32'd7, 1'b1);
        wait_idle();
        checks++;
        if (rx1_q.size() != 2 || rx1_q[0] !== 32'd3 || rx1_q[1] !== 32'd4) begin
            failures++;
            $display("FAIL skip_data: got %p required '{3,4}", rx1_q);
        end
        checks++;
        if (rows_sent1 !== 32'd3) begin
            failures++;
            $display("FAIL skip_rows: rows_sent=%0d required 3", rows_sent1);
        end
        checks++;
        if (done1_cnt != 1 || rx1_cyc.size() != 2 || done1_cyc != rx1_cyc[1] + 1) begin
            failures++;
            $display("FAIL skip_done: count=%0d cyc=%0d required 1 pulse after last row",
                     done1_cnt, done1_cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit stop = 0;
        int bad = 0;
        clear_obs();
        fork
            begin
                for (int i = 0; i <= 64; i++) send(32'(2 * i), (i == 64));
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    times_ready = ~times_ready;
                end
            end
        join
        times_ready = 1'b1;
        wait_idle();
        foreach (rx_q[k]) if (rx_q[k] !== 32'd2) bad++;
        checks++;
        if (rx_q.size() != 64 || bad != 0) begin
            failures++;
            $display("FAIL b2b_data: count=%0d nonmatching=%0d required 64 values of 2",
                     rx_q.size(), bad);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL b2b_stable: stall violations=%0d required 0", stall_viol);
        end
        checks++;
        if (full_viol != 0) begin
            failures++;
            $display("FAIL b2b_full_ready: ready-while-full=%0d required 0", full_viol);
        end
        checks++;
        if (done_cnt != 1 || rows_sent !== 32'd64) begin
            failures++;
            $display("FAIL b2b_done: done=%0d rows_sent=%0d required 1 64", done_cnt, rows_sent);
        end
    endtask

    task automatic test_err();
        clear_obs();
        send(32'd10, 1'b0);
        send(32'd5, 1'b1);
        wait_idle();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 32'd0 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_decrease: rx=%p err=%0b required '{0} 1", rx_q, err);
        end
        clear_obs();
        send(32'd0, 1'b0);
        send(32'd4, 1'b1);
        wait_idle();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 32'd4 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: rx=%p err=%0b required '{4} 1", rx_q, err);
        end
    endtask

    task automatic test_single();
        clear_obs();
        send(32'd42, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || done_cnt != 1 || busy_seen) begin
            failures++;
            $display("FAIL single_ptr: rx=%0d done=%0d busy_seen=%0b required 0 1 0",
                     rx_q.size(), done_cnt, busy_seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        clear_obs();
        times_ready = 1'b0;
        send(32'd0, 1'b0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        @(negedge clk);
        checks++;
        if ({ptr_ready, times_valid, busy, err} !== 4'b0111 || times_data !== 32'd1 ||
            rows_sent !== 32'd2) begin
            failures++;
            $display("FAIL mid_full: rdy,vld,busy,err=%b data=%0d rows=%0d required 0111 1 2",
                     {ptr_ready, times_valid, busy, err}, times_data, rows_sent);
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({ptr_ready, times_valid, busy, err} !== 4'b0 || rows_sent !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: rdy,vld,busy,err=%b rows=%0d required 0000 0",
                     {ptr_ready, times_valid, busy, err}, rows_sent);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL mid_no_done: done=%0b count=%0d required 0 0", done, done_cnt);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        times_ready = 1'b1;
        clear_obs();
        send(32'd0, 1'b0);
        send(32'd1, 1'b1);
        wait_idle();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 32'd1 || done_cnt != 1) begin
            failures++;
            $display("FAIL mid_recover: rx=%p done=%0d required '{1} 1", rx_q, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip_zero();
        test_back_to_back();
        test_err();
        test_single();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
